// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// ratio and the ceil(log2) helper used to size counters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int unsigned DEF_OVERSAMPLING = 16;

  // Smallest width able to hold values 0..n-1; never less than 1 bit.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input; resets to the
// idle-high level so a line in reset never looks like a start edge.
module bit_synchronizer (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '1;
    else          sync_q <= {sync_q[0], i_d};
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled (configurable) serial input, centre-bit
// sampling, one-cycle done / frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NB_STOP      = 1,
  parameter int unsigned OVERSAMPLING = DEF_OVERSAMPLING
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  // s_cnt must also span the whole stop period, which is longer than one
  // bit when two stop bits are used.
  localparam int unsigned SCNT_W = clogb2(NB_STOP * OVERSAMPLING);
  localparam int unsigned NCNT_W = clogb2(NB_DATA);

  localparam logic [SCNT_W-1:0] START_LAST = SCNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [SCNT_W-1:0] BIT_LAST   = SCNT_W'(OVERSAMPLING - 1);
  localparam logic [SCNT_W-1:0] STOP_LAST  = SCNT_W'(NB_STOP * OVERSAMPLING - 1);
  localparam logic [NCNT_W-1:0] NBIT_LAST  = NCNT_W'(NB_DATA - 1);

  logic               rx_s;
  logic               rx_prev_q;
  rx_state_e          state_q;
  logic [SCNT_W-1:0]  s_cnt_q;
  logic [NCNT_W-1:0]  n_cnt_q;
  logic [NB_DATA-1:0] shift_q;
  logic [NB_DATA-1:0] data_q;
  logic               done_q;
  logic               err_q;

  bit_synchronizer u_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_s;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s) begin
            state_q <= START;
            s_cnt_q <= '0;
          end
        end
        START: begin
          if (i_tick) begin
            if (s_cnt_q == START_LAST) begin
              if (!rx_s) begin
                state_q <= DATA;
                s_cnt_q <= '0;
                n_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + SCNT_W'(1);
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (s_cnt_q == BIT_LAST) begin
              s_cnt_q <= '0;
              shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
              if (n_cnt_q == NBIT_LAST) state_q <= STOP;
              else                      n_cnt_q <= n_cnt_q + NCNT_W'(1);
            end else begin
              s_cnt_q <= s_cnt_q + SCNT_W'(1);
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (s_cnt_q == STOP_LAST) begin
              state_q <= IDLE;
              if (rx_s) begin
                data_q <= shift_q;
                done_q <= 1'b1;
              end else begin
                err_q  <= 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + SCNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboarded frames on an 8N1 instance and a
// 7-bit / 2-stop instance, with glitch, break and mid-frame reset cases.
module tb_uart_rx;

  localparam int BIT = 64;  // 16 ticks x 4 clk

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       rx1   = 1'b1;
  logic       rx2   = 1'b1;
  logic [7:0] data1;
  logic       done1, err1;
  logic [6:0] data2;
  logic       done2, err2;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp1[$];
  logic [6:0] exp2[$];
  logic [7:0] last_good = 8'h00;
  logic [1:0] tdiv = 2'd0;
  logic       arm2 = 1'b0;
  int         pidx2 = 0;
  int         tcnt2 = 0;

  uart_rx #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLING(16)) dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx1),
    .o_data(data1), .o_rx_done(done1), .o_frame_err(err1)
  );

  uart_rx #(.NB_DATA(7), .NB_STOP(2), .OVERSAMPLING(16)) dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx2),
    .o_data(data2), .o_rx_done(done2), .o_frame_err(err2)
  );

  always #5 clk = ~clk;

  // Tick is one clk wide every 4 clk, changing on the falling edge.
  always @(negedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'd3);
  end

  // Ticks seen by dut2 from the 4th rising edge after its start edge is driven.
  always @(posedge clk) begin
    if (arm2) begin
      pidx2 <= pidx2 + 1;
      if (pidx2 + 1 >= 4 && tick) tcnt2 <= tcnt2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e1;
    logic [6:0] e2;
    if (done1 || err1) begin
      chk("excl1", 32'(done1 & err1), 32'd0);
      if (exp1.size() == 0) begin
        chk("pending1", 32'(exp1.size()), 32'd1);
      end else begin
        e1 = exp1.pop_front();
        chk("kind1", 32'(err1), 32'(e1[8]));
        chk("data1", 32'(data1), 32'(e1[7:0]));
      end
    end
    if (done2 || err2) begin
      chk("err2", 32'(err2), 32'd0);
      chk("lat2", 32'(tcnt2), 32'd152);
      if (exp2.size() == 0) begin
        chk("pending2", 32'(exp2.size()), 32'd1);
      end else begin
        e2 = exp2.pop_front();
        chk("data2", 32'(data2), 32'(e2));
      end
    end
  end

  task automatic drive1(input logic v, input int n);
    rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive2(input logic v, input int n);
    rx2 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) begin
      exp1.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp1.push_back({1'b1, last_good});
    end
    drive1(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive1(d[i], BIT);
    drive1(stop_ok, BIT);
  endtask

  initial begin
    logic [7:0] partial;
    logic [6:0] d7;
    partial = 8'h5A;
    d7      = 7'h55;

    repeat (3) @(negedge clk);
    chk("rst_data1", 32'(data1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_err1",  32'(err1),  32'd0);
    chk("rst_data2", 32'(data2), 32'd0);
    rst_n = 1'b1;
    drive1(1'b1, 2 * BIT);

    send1(8'hA5, 1'b1);
    drive1(1'b1, BIT);

    send1(8'h00, 1'b1);
    send1(8'hFF, 1'b1);
    drive1(1'b1, 2 * BIT);

    drive1(1'b0, 20);
    drive1(1'b1, 2 * BIT);
    chk("glitch_hold", 32'(data1), 32'(last_good));

    send1(8'h3C, 1'b0);
    drive1(1'b0, 40 * BIT);
    chk("break_hold", 32'(data1), 32'(last_good));
    drive1(1'b1, 2 * BIT);

    drive1(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive1(partial[i], BIT);
    drive1(partial[4], BIT / 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_data", 32'(data1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    chk("midrst_err",  32'(err1),  32'd0);
    rst_n = 1'b1;
    last_good = 8'h00;
    drive1(1'b1, 3 * BIT);
    chk("post_rst_data", 32'(data1), 32'd0);
    send1(8'hC3, 1'b1);
    drive1(1'b1, 2 * BIT);

    exp2.push_back(d7);
    pidx2 = 0;
    tcnt2 = 0;
    arm2  = 1'b1;
    drive2(1'b0, BIT);
    for (int i = 0; i < 7; i++) drive2(d7[i], BIT);
    drive2(1'b1, 2 * BIT);
    drive2(1'b1, BIT);
    arm2 = 1'b0;

    chk("drain1", 32'(exp1.size()), 32'd0);
    chk("drain2", 32'(exp2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
